// File: rtl/i3c_target_device_if.sv
// i3c_target_device_if: SCL/SDA bus lines and IBI handshake of the I3C target.
interface i3c_target_device_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe;
    logic       ibi_req;
    logic       ibi_busy;
    logic       ibi_done;
    logic       da_valid;
    logic [6:0] dyn_addr;
    modport master (output scl_i, sda_i, ibi_req, input sda_oe, dyn_addr, da_valid, ibi_busy, ibi_done);
    modport slave (input scl_i, sda_i, ibi_req, output sda_oe, dyn_addr, da_valid, ibi_busy, ibi_done);
endinterface

// File: rtl/i3c_target_device.sv
// i3c_target_device: I3C target answering ENTDAA, GETCAPS and RSTDAA, raising IBIs on an idle bus.
// Define I3C_TGT_PARITY_EN to require odd parity on the address byte assigned during ENTDAA.
module i3c_target_device #(
    parameter logic [7:0]  STATIC_ADDR     = 8'h50,
    parameter logic [7:0]  BCR_VAL         = 8'h06,
    parameter logic [7:0]  DCR_VAL         = 8'h00,
    parameter logic [7:0]  LVR_VAL         = 8'h00,
    parameter int unsigned IDLE_CYCLES     = 8,
    parameter int unsigned IBI_HOLD_CYCLES = 16
) (
    input logic clk,
    input logic reset_n,
    i3c_target_device_if.slave bus
);
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam int HW = $clog2(IBI_HOLD_CYCLES + 1);
    localparam logic [31:0] TX_WORD = {BCR_VAL, DCR_VAL, LVR_VAL, STATIC_ADDR};

    typedef enum logic [2:0] {IDLE, CMD, DAA_TX, DAA_RX, ADDR, CAPS_TX, IGNORE, IBI} state_t;
    state_t state, state_n;
    logic [1:0] scl_s, sda_s;
    logic scl, sda, scl_q, sda_q;
    logic scl_rise, scl_fall, start, stop;
    logic rx, tx, ack, ack_go, ack_end, tx_done, tx_bit, bus_idle, rstdaa, par_ok;
    logic [5:0] cnt, cnt_n;
    logic [7:0] sh, sh_n;
    logic [IW-1:0] idle_cnt, idle_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic oe, oe_n, dav, dav_n, busy, busy_n, done, done_n;
    logic [6:0] addr, addr_n;

    assign scl = scl_s[1];
    assign sda = sda_s[1];
    assign scl_rise = scl & ~scl_q;
    assign scl_fall = ~scl & scl_q;
    assign start = scl & scl_q & sda_q & ~sda;
    assign stop = scl & scl_q & ~sda_q & sda;
    assign rx = state inside {CMD, DAA_RX, ADDR};
    assign tx = state inside {DAA_TX, CAPS_TX};
    // cnt 8: byte received, ACK slot opens at next fall; cnt 9: inside ACK slot
    assign ack_go = scl_fall && cnt == 6'd8;
    assign ack_end = scl_fall && cnt == 6'd9;
    assign tx_done = scl_fall && cnt == (state == DAA_TX ? 6'd32 : 6'd24);
    assign tx_bit = TX_WORD[5'd31 - cnt[4:0]];
    assign bus_idle = idle_cnt == IW'(IDLE_CYCLES);
    assign rstdaa = state == CMD && ack_end && sh == 8'h06;
`ifdef I3C_TGT_PARITY_EN
    assign par_ok = sh[0] == ~^sh[7:1];
`else
    assign par_ok = 1'b1;
`endif
    assign ack = state == CMD ? (sh == 8'h07 && !dav) || sh == 8'h06
               : state == ADDR ? sh[7:1] == addr && !sh[0] && dav
               : par_ok;

    assign bus.sda_oe = oe;
    assign bus.dyn_addr = addr;
    assign bus.da_valid = dav;
    assign bus.ibi_busy = busy;
    assign bus.ibi_done = done;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state <= IDLE;
            scl_s <= 2'b11;
            sda_s <= 2'b11;
            scl_q <= 1'b1;
            sda_q <= 1'b1;
            cnt <= '0;
            sh <= '0;
            idle_cnt <= '0;
            hold_cnt <= '0;
            oe <= 1'b0;
            dav <= 1'b0;
            addr <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_n;
            scl_s <= {scl_s[0], bus.scl_i};
            sda_s <= {sda_s[0], bus.sda_i};
            scl_q <= scl;
            sda_q <= sda;
            cnt <= cnt_n;
            sh <= sh_n;
            idle_cnt <= idle_n;
            hold_cnt <= hold_n;
            oe <= oe_n;
            dav <= dav_n;
            addr <= addr_n;
            busy <= busy_n;
            done <= done_n;
        end

    // IBI ignores START/STOP: its own SDA pull and release would look like both
    always_comb begin
        state_n = state;
        if (state == IBI)
            state_n = (scl_fall || hold_cnt == HW'(IBI_HOLD_CYCLES - 1)) ? IDLE : IBI;
        else if (start)
            state_n = CMD;
        else if (stop)
            state_n = IDLE;
        else
            case (state)
                IDLE: state_n = (busy && bus_idle) ? IBI : IDLE;
                CMD: if (ack_end) state_n = (sh == 8'h07 && !dav) ? DAA_TX : sh == 8'h08 ? ADDR : IGNORE;
                ADDR: if (ack_end) state_n = ack ? CAPS_TX : IGNORE;
                DAA_RX: if (ack_end) state_n = IGNORE;
                DAA_TX: if (tx_done) state_n = DAA_RX;
                CAPS_TX: if (tx_done) state_n = IGNORE;
                default: ;
            endcase
    end

    always_comb begin
        cnt_n = cnt;
        sh_n = sh;
        oe_n = oe;
        dav_n = dav;
        addr_n = addr;
        idle_n = '0;
        hold_n = '0;
        done_n = 1'b0;
        busy_n = done ? 1'b0 : busy | (bus.ibi_req & dav);
        if (state == IBI) begin
            hold_n = hold_cnt + 1'b1;
            oe_n = state_n == IBI;
            done_n = state_n != IBI;
        end else if (start || stop) begin
            cnt_n = '0;
            oe_n = 1'b0;
        end else if (state == IDLE) begin
            idle_n = ((scl ^ scl_q) || (sda ^ sda_q)) ? '0 : (scl && sda && !bus_idle) ? idle_cnt + 1'b1 : idle_cnt;
            oe_n = state_n == IBI;
        end else if (rx) begin
            if (scl_rise && cnt < 6'd8) begin
                sh_n = {sh[6:0], sda};
                cnt_n = cnt + 1'b1;
            end
            if (ack_go) begin
                cnt_n = 6'd9;
                oe_n = ack;
            end
            if (ack_end) begin
                cnt_n = '0;
                oe_n = (state_n == DAA_TX || state_n == CAPS_TX) && !TX_WORD[31];
                if (state == DAA_RX && ack) begin
                    dav_n = 1'b1;
                    addr_n = sh[7:1];
                end
                if (rstdaa) begin
                    dav_n = 1'b0;
                    addr_n = '0;
                    busy_n = 1'b0;
                end
            end
        end else if (tx) begin
            if (scl_rise)
                cnt_n = cnt + 1'b1;
            if (scl_fall) begin
                cnt_n = tx_done ? '0 : cnt;
                oe_n = !tx_done && !tx_bit;
            end
        end else
            oe_n = 1'b0;
    end
endmodule

// File: tb/tb_i3c_target_device.sv
// tb_i3c_target_device: bus-master driven bench with a transaction-level model of the target.
module tb_i3c_target_device;
    localparam int HP = 8;
    localparam logic [31:0] IDS = 32'h0600_0050;
    localparam logic [31:0] CAPS = 32'h0006_0000;
    logic clk = 1'b0, reset_n = 1'b0, mscl = 1'b1, msda = 1'b1;
    logic m_dav = 1'b0, m_busy = 1'b0, mon_en = 1'b0, quiet = 1'b0;
    logic [6:0] m_dyn = '0;
    int vectors = 0, errors = 0;

    i3c_target_device_if bus();
    assign bus.scl_i = mscl;
    assign bus.sda_i = msda & ~bus.sda_oe;
    i3c_target_device dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (reset_n) begin
        if (mon_en) begin
            check("da_valid", 32'(bus.da_valid), 32'(m_dav));
            check("dyn_addr", 32'(bus.dyn_addr), 32'(m_dyn));
            check("ibi_busy", 32'(bus.ibi_busy), 32'(m_busy));
            check("ibi_done_idle", 32'(bus.ibi_done), 32'd0);
        end
        if (quiet)
            check("sda_released", 32'(bus.sda_oe), 32'd0);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic xbit(input logic b, output logic r);
        msda = b;
        tick(HP);
        mscl = 1'b1;
        tick(HP / 2);
        r = bus.sda_i;
        tick(HP / 2);
        mscl = 1'b0;
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) xbit(d[i], r);
        xbit(1'b1, r);
        ack = ~r;
    endtask

    task automatic rbits(input int n, output logic [31:0] d);
        logic r;
        d = '0;
        for (int i = 0; i < n; i++) begin
            xbit(1'b1, r);
            d = {d[30:0], r};
        end
    endtask

    task automatic start_c;
        mon_en = 1'b0;
        msda = 1'b1;
        mscl = 1'b1;
        tick(HP);
        msda = 1'b0;
        tick(HP);
        mscl = 1'b0;
    endtask

    task automatic finish_c;
        msda = 1'b0;
        tick(HP);
        mscl = 1'b1;
        tick(HP);
        msda = 1'b1;
        tick(HP);
        quiet = 1'b0;
        tick(4);
        mon_en = 1'b1;
    endtask

    function automatic logic addr_ok(input logic [7:0] a);
`ifdef I3C_TGT_PARITY_EN
        return $countones(a) % 2 == 1;
`else
        return 1'b1;
`endif
    endfunction

    task automatic entdaa(input logic [7:0] a);
        logic ack;
        logic [31:0] d;
        start_c;
        quiet = m_dav;
        wbyte(8'h07, ack);
        check("entdaa_ack", 32'(ack), 32'(!m_dav));
        if (!m_dav) begin
            rbits(32, d);
            check("daa_ids", d, IDS);
            wbyte(a, ack);
            check("daa_addr_ack", 32'(ack), 32'(addr_ok(a)));
            if (addr_ok(a)) begin
                m_dav = 1'b1;
                m_dyn = a[7:1];
            end
        end
        finish_c;
    endtask

    task automatic getcaps(input logic [7:0] a);
        logic ack, match;
        logic [31:0] d;
        start_c;
        match = m_dav && a[7:1] == m_dyn && !a[0];
        quiet = !match;
        wbyte(8'h08, ack);
        check("getcaps_cmd_nack", 32'(ack), 32'd0);
        wbyte(a, ack);
        check("getcaps_addr_ack", 32'(ack), 32'(match));
        if (match) begin
            rbits(24, d);
            check("getcaps_data", d, CAPS);
        end
        finish_c;
    endtask

    task automatic rstdaa;
        logic ack;
        start_c;
        wbyte(8'h06, ack);
        check("rstdaa_ack", 32'(ack), 32'd1);
        m_dav = 1'b0;
        m_dyn = '0;
        m_busy = 1'b0;
        finish_c;
    endtask

    task automatic other_cmd(input logic [7:0] c);
        logic ack;
        start_c;
        quiet = 1'b1;
        wbyte(c, ack);
        check("other_nack", 32'(ack), 32'd0);
        finish_c;
    endtask

    task automatic ibi;
        int t, n;
        mon_en = 1'b0;
        tick(12);
        bus.ibi_req = 1'b1;
        tick(1);
        bus.ibi_req = 1'b0;
        if (!m_dav) begin
            quiet = 1'b1;
            tick(40);
            quiet = 1'b0;
            check("ibi_dropped", 32'(bus.ibi_busy), 32'd0);
        end else begin
            t = 0;
            while (!bus.sda_oe && t < 20) begin tick(1); t++; end
            check("ibi_start", 32'(t < 20), 32'd1);
            n = 0;
            while (bus.sda_oe && n < 40) begin tick(1); n++; end
            check("ibi_hold_len", n, 32'd16);
            check("ibi_done_pulse", 32'(bus.ibi_done), 32'd1);
            check("ibi_busy_at_done", 32'(bus.ibi_busy), 32'd1);
            tick(1);
            check("ibi_done_end", 32'(bus.ibi_done), 32'd0);
            check("ibi_busy_clear", 32'(bus.ibi_busy), 32'd0);
        end
        tick(8);
        mon_en = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic ack, r;
        logic [7:0] c, first_addr;
        bus.ibi_req = 1'b0;
`ifdef I3C_TGT_PARITY_EN
        first_addr = 8'h20;
`else
        first_addr = 8'h21;
`endif
        tick(3);
        check("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
        check("rst_dyn_addr", 32'(bus.dyn_addr), 32'd0);
        check("rst_da_valid", 32'(bus.da_valid), 32'd0);
        check("rst_ibi_busy", 32'(bus.ibi_busy), 32'd0);
        check("rst_ibi_done", 32'(bus.ibi_done), 32'd0);
        reset_n = 1'b1;
        tick(20);
        mon_en = 1'b1;
        entdaa(first_addr);
        check("first_dyn_addr", 32'(bus.dyn_addr), 32'h10);
        check("first_da_valid", 32'(bus.da_valid), 32'd1);
        entdaa(8'h33);
        getcaps(8'h20);
        getcaps(8'h22);
        ibi;
        start_c;
        bus.ibi_req = 1'b1;
        tick(1);
        bus.ibi_req = 1'b0;
        tick(1);
        check("busy_in_frame", 32'(bus.ibi_busy), 32'd1);
        wbyte(8'h06, ack);
        check("rstdaa_busy_ack", 32'(ack), 32'd1);
        m_dav = 1'b0;
        m_dyn = '0;
        m_busy = 1'b0;
        finish_c;
        quiet = 1'b1;
        tick(40);
        quiet = 1'b0;
        ibi;
`ifdef I3C_TGT_PARITY_EN
        entdaa(8'h21);
        check("parity_reject", 32'(bus.da_valid), 32'd0);
`endif
        rstdaa;
        start_c;
        wbyte(8'h07, ack);
        check("daa_reset_ack", 32'(ack), 32'd1);
        xbit(1'b1, r);
        check("bcr_msb", 32'(r), 32'd0);
        check("pre_reset_drive", 32'(bus.sda_oe), 32'd1);
        #3 reset_n = 1'b0;
        #1;
        check("async_rst_sda_oe", 32'(bus.sda_oe), 32'd0);
        check("async_rst_da_valid", 32'(bus.da_valid), 32'd0);
        check("async_rst_dyn_addr", 32'(bus.dyn_addr), 32'd0);
        check("async_rst_ibi_busy", 32'(bus.ibi_busy), 32'd0);
        mscl = 1'b1;
        msda = 1'b1;
        tick(3);
        reset_n = 1'b1;
        m_dav = 1'b0;
        m_dyn = '0;
        m_busy = 1'b0;
        tick(20);
        mon_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            c = 8'($urandom);
            case ($urandom_range(0, 4))
                0: entdaa(c);
                1: getcaps($urandom_range(0, 1) ? {m_dyn, 1'b0} : c);
                2: rstdaa;
                3: ibi;
                default: begin
                    if (c inside {8'h06, 8'h07, 8'h08}) c[7] = 1'b1;
                    other_cmd(c);
                end
            endcase
        end
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
